// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: instruction layout, op codes, register-file geometry.
package alu_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int NREGS      = 8;
    localparam int REG_AW     = 3;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RSA_MSB = 8;
    localparam int RSA_LSB = 6;
    localparam int RSB_MSB = 5;
    localparam int RSB_LSB = 3;
    localparam int CIN_BIT = 2;
    localparam int RSV_MSB = 1;
    localparam int RSV_LSB = 0;

    typedef logic [3:0] op_t;
    localparam op_t OP_NOP = 4'b1111;

    typedef struct packed {
        op_t               op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs_a;
        logic [REG_AW-1:0] rs_b;
        logic              cin;
        logic [1:0]        rsvd;
    } instr_t;

    function automatic instr_t to_instr(input logic [15:0] w);
        instr_t t;
        t.op   = op_t'(w[OP_MSB:OP_LSB]);
        t.rd   = w[RD_MSB:RD_LSB];
        t.rs_a = w[RSA_MSB:RSA_LSB];
        t.rs_b = w[RSB_MSB:RSB_LSB];
        t.cin  = w[CIN_BIT];
        t.rsvd = w[RSV_MSB:RSV_LSB];
        return t;
    endfunction

    function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
        return NREGS'(1) << r;
    endfunction
endpackage

// File: rtl/alu_issue_if.sv
// Bundle of instruction-in, operand-out, writeback and status signals around the issue stage.
interface alu_issue_if #(parameter int DATA_W = 16);
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr;
    logic              issue_valid;
    logic              issue_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              cin;
    logic [3:0]        sel;
    logic [2:0]        issue_rd;
    logic              wb_valid;
    logic [2:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              busy;

    modport master (
        output instr_valid, instr, issue_ready, wb_valid, wb_rd, wb_data,
        input  instr_ready, issue_valid, in_a, in_b, cin, sel, issue_rd, busy
    );

    modport slave (
        input  instr_valid, instr, issue_ready, wb_valid, wb_rd, wb_data,
        output instr_ready, issue_valid, in_a, in_b, cin, sel, issue_rd, busy
    );
endinterface

// File: rtl/alu_issue_fifo.sv
// In-order instruction buffer; head entry is readable combinationally so hazards can be judged the same cycle.
module alu_issue_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/alu_issue.sv
// Issue stage: buffers instructions, checks the pending scoreboard, reads operands and registers the ALU bundle.
// Optional macro ALU_ISSUE_BYPASS_EN forwards the current writeback into hazard check and operand read.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  bus
);
    logic [15:0]                   fifo_rdata;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          push;
    logic                          pop;
    instr_t                        head;
    logic                          head_nop;
    logic                          hazard;
    logic                          load;
    logic                          drop;
    logic [NREGS-1:0]              wb_hit;
    logic [NREGS-1:0]              pend_eff;
    logic [DATA_W-1:0]             opnd_a;
    logic [DATA_W-1:0]             opnd_b;
    logic                          unused_rsvd;

    logic [DATA_W-1:0]             regs_q [NREGS];
    logic [NREGS-1:0]              pending_q;
    logic [NREGS-1:0]              pending_d;
    logic                          issue_valid_q;
    logic [DATA_W-1:0]             in_a_q;
    logic [DATA_W-1:0]             in_b_q;
    logic                          cin_q;
    op_t                           sel_q;
    logic [REG_AW-1:0]             issue_rd_q;

    assign push = bus.instr_valid && bus.instr_ready;
    assign pop  = load || drop;

    alu_issue_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (bus.instr),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head        = to_instr(fifo_rdata);
    assign unused_rsvd = ^head.rsvd;
    assign head_nop    = (head.op == OP_NOP);
    assign wb_hit      = bus.wb_valid ? reg_onehot(bus.wb_rd) : '0;

`ifdef ALU_ISSUE_BYPASS_EN
    assign pend_eff = pending_q & ~wb_hit;
`else
    assign pend_eff = pending_q;
`endif

    assign hazard = pend_eff[head.rs_a] || pend_eff[head.rs_b] || pend_eff[head.rd];
    assign drop   = !fifo_empty && head_nop;
    assign load   = !fifo_empty && !head_nop && !hazard && (!issue_valid_q || bus.issue_ready);

    always_comb begin
        opnd_a = regs_q[head.rs_a];
        opnd_b = regs_q[head.rs_b];
`ifdef ALU_ISSUE_BYPASS_EN
        if (bus.wb_valid && bus.wb_rd == head.rs_a && head.rs_a != '0) opnd_a = bus.wb_data;
        if (bus.wb_valid && bus.wb_rd == head.rs_b && head.rs_b != '0) opnd_b = bus.wb_data;
`endif
    end

    // r0 is never written, so it stays at its reset value of zero.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs_q[gi] <= '0;
            end else if (gi != 0 && bus.wb_valid && bus.wb_rd == REG_AW'(gi)) begin
                regs_q[gi] <= bus.wb_data;
            end
        end
    end

    // A load setting the same bit a writeback clears takes priority.
    always_comb begin
        pending_d = pending_q & ~wb_hit;
        if (load) pending_d = pending_d | reg_onehot(head.rd);
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            issue_valid_q <= 1'b0;
            in_a_q        <= '0;
            in_b_q        <= '0;
            cin_q         <= 1'b0;
            sel_q         <= '0;
            issue_rd_q    <= '0;
        end else begin
            pending_q <= pending_d;
            if (load) begin
                issue_valid_q <= 1'b1;
                in_a_q        <= opnd_a;
                in_b_q        <= opnd_b;
                cin_q         <= head.cin;
                sel_q         <= head.op;
                issue_rd_q    <= head.rd;
            end else if (bus.issue_ready) begin
                issue_valid_q <= 1'b0;
            end
        end
    end

    assign bus.instr_ready = !fifo_full;
    assign bus.issue_valid = issue_valid_q;
    assign bus.in_a        = in_a_q;
    assign bus.in_b        = in_b_q;
    assign bus.cin         = cin_q;
    assign bus.sel         = sel_q;
    assign bus.issue_rd    = issue_rd_q;
    assign bus.busy        = (fifo_count != '0) || issue_valid_q || (|pending_q);
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a transaction-level scoreboard of expected issues.
`timescale 1ns/1ps
module tb_alu_issue;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if #(.DATA_W(16)) bus();

    alu_issue #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs_a;
        logic [2:0] rs_b;
        logic       cin;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_regs [8];
    bit          m_pend [8];
    bit          seen;
    logic [15:0] exp_a, exp_b;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_issued = 0;
    int          cyc = 0;
    int          load_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end else begin
            $display("check %s ok: %0h", name, act);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        seen = 1'b0;
    endtask

    task automatic model_push(input logic [15:0] w);
        exp_t e;
        e.op   = w[15:12];
        e.rd   = w[11:9];
        e.rs_a = w[8:6];
        e.rs_b = w[5:3];
        e.cin  = w[2];
        if (e.op != 4'hF) exp_q.push_back(e);
    endtask

    // Scoreboard: every visible bundle must be the oldest non-NOP instruction with hazard-free operands.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.issue_valid) begin
                chk("issue_expected", bus.issue_valid, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    if (!seen) begin
                        chk("hazard_clear", {m_pend[e.rs_a], m_pend[e.rs_b], m_pend[e.rd]}, 0);
                        exp_a = m_regs[e.rs_a];
                        exp_b = m_regs[e.rs_b];
                        if (e.rd != 0) m_pend[e.rd] = 1'b1;
                        seen = 1'b1;
                        load_cyc.push_back(cyc);
                    end
                    chk("bundle", {bus.sel, bus.issue_rd, bus.cin, bus.in_a, bus.in_b},
                        {e.op, e.rd, e.cin, exp_a, exp_b});
                    if (bus.issue_ready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                        n_issued++;
                        $display("issue #%0d sel=%0h rd=%0d a=%04h b=%04h", n_issued, bus.sel, bus.issue_rd, bus.in_a, bus.in_b);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [15:0] w);
        int t = 0;
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        @(negedge clk);
        while (!bus.instr_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.instr_ready) chk("push_timeout", bus.instr_ready, 1);
        @(posedge clk);
        #1;
        model_push(w);
        $display("push %04h", w);
        bus.instr_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [2:0] r, input logic [15:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = r;
        bus.wb_data  = d;
        @(posedge clk);
        #1;
        if (r != 0) m_regs[r] = d;
        m_pend[r] = 1'b0;
        bus.wb_valid = 1'b0;
        $display("wb r%0d=%04h", r, d);
    endtask

    task automatic wait_drain(input int max);
        int t = 0;
        while (exp_q.size() != 0 && t < max) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n0, l0;
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h1650;
        bus.issue_ready = 1'b1;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
        model_reset();
        fork
            monitor();
        join_none

        // Reset held with an instruction offered
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_instr_ready", bus.instr_ready, 1);
        chk("rst_issue_valid", bus.issue_valid, 0);
        chk("rst_outputs", {bus.in_a, bus.in_b, bus.cin, bus.sel, bus.issue_rd}, 0);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("no_push_in_reset", bus.busy, 0);

        // Basic issue after preloading r1/r2
        do_wb(3'd1, 16'h0005);
        do_wb(3'd2, 16'h0003);
        push(16'h1650);
        @(negedge clk);
        chk("latency_min", bus.issue_valid, 0);
        @(negedge clk);
        chk("basic_valid", bus.issue_valid, 1);
        chk("basic_in_a", bus.in_a, 16'h0005);
        chk("basic_in_b", bus.in_b, 16'h0003);
        chk("basic_sel_rd", {bus.sel, bus.issue_rd, bus.cin}, {4'h1, 3'd3, 1'b0});
        @(negedge clk);
        chk("pending_busy", {bus.issue_valid, bus.busy}, 2'b01);
        do_wb(3'd3, 16'h0008);
        @(negedge clk);
        chk("wb_clears_busy", bus.busy, 0);

        // RAW stall on a back-to-back dependency
        do_reset();
        do_wb(3'd1, 16'h0005);
        do_wb(3'd2, 16'h0003);
        push(16'h1650);
        push(16'h28C0);
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("raw_stall", bus.issue_valid, 0);
        end
        do_wb(3'd3, 16'h0008);
        @(negedge clk);
`ifndef ALU_ISSUE_BYPASS_EN
        chk("no_bypass_wait", bus.issue_valid, 0);
        @(negedge clk);
`endif
        chk("dep_valid", bus.issue_valid, 1);
        chk("dep_in_a", bus.in_a, 16'h0008);
        chk("dep_rd", bus.issue_rd, 3'd4);
        wait_drain(10);

        // Back-pressure fills the buffer
        do_reset();
        bus.issue_ready = 1'b0;
        n0 = n_issued;
        for (int k = 1; k <= 5; k++) push(16'((k << 12) | (k << 9) | ((k & 1) << 2)));
        @(negedge clk);
        chk("full_ready_low", bus.instr_ready, 0);
        chk("full_head_sel", {bus.issue_valid, bus.sel}, {1'b1, 4'h1});
        repeat (3) @(negedge clk);
        chk("full_still_low", bus.instr_ready, 0);
        @(posedge clk);
        #1;
        bus.issue_ready = 1'b1;
        wait_drain(30);
        chk("drain_count", n_issued - n0, 5);

        // NOP between two independent ops
        do_reset();
        n0 = n_issued;
        l0 = load_cyc.size();
        push(16'h1200);
        push(16'hF000);
        push(16'h2400);
        wait_drain(20);
        chk("nop_issue_count", n_issued - n0, 2);
        if (load_cyc.size() >= l0 + 2) chk("nop_gap", load_cyc[l0+1] - load_cyc[l0], 2);
        else chk("nop_loads_seen", load_cyc.size() - l0, 2);

        // r0 reads zero; reset during a stall
        do_reset();
        do_wb(3'd0, 16'hFFFF);
        push(16'h3A00);
        @(negedge clk);
        @(negedge clk);
        chk("r0_valid", bus.issue_valid, 1);
        chk("r0_in_a", bus.in_a, 16'h0000);
        push(16'h1340);
        repeat (2) @(negedge clk);
        chk("stall_busy", {bus.issue_valid, bus.busy}, 2'b01);
        #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ready", bus.instr_ready, 1);
        chk("mid_rst_valid", bus.issue_valid, 0);
        repeat (3) @(negedge clk);
        chk("mid_rst_quiet", {bus.issue_valid, bus.busy}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
